// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one registered memory request per load/store, stalls until
// mem_ready, then loads the MEM/WB register. Optional feature macro: MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int unsigned MEM_AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       DR,
  input  logic [4:0]        DR_num,
  input  logic [31:0]       WriteData,
  input  logic [31:0]       PC_plus_4,
  input  logic [1:0]        ResultSrc,
  input  logic              RegWrite,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        funct3,
  output logic [31:0]       ALUResData,
  output logic              StallReq,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       WB_ALURes,
  output logic [31:0]       WB_ReadData,
  output logic [31:0]       WB_PC_plus_4,
  output logic [4:0]        WB_DR_num,
  output logic [1:0]        WB_ResultSrc,
  output logic              WB_RegWrite,
  output logic              MisalignErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wb_alu_res_q, wb_alu_res_d;
  logic [31:0]       wb_read_data_q, wb_read_data_d;
  logic [31:0]       wb_pc_plus_4_q, wb_pc_plus_4_d;
  logic [4:0]        wb_dr_num_q, wb_dr_num_d;
  logic [1:0]        wb_result_src_q, wb_result_src_d;
  logic              wb_reg_write_q, wb_reg_write_d;

  logic        access, trap, stall;
  logic [31:0] st_wdata, load_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
  logic misalign, misalign_err_q, misalign_err_d;
  assign misalign = ((funct3[1:0] == 2'b01) & DR[0]) |
                    ((funct3[1:0] == 2'b10) & (DR[1:0] != 2'b00));
  assign trap           = (state_q == IDLE) & access & misalign;
  assign misalign_err_d = trap;
  assign MisalignErr    = misalign_err_q;
  always_ff @(posedge clk) begin
    if (reset) misalign_err_q <= 1'b0;
    else       misalign_err_q <= misalign_err_d;
  end
`else
  assign trap        = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  always_comb begin
    st_wdata = WriteData;
    st_wstrb = 4'b0000;
    case (funct3)
      3'b000: begin
        st_wdata = {4{WriteData[7:0]}};
        st_wstrb = 4'b0001 << DR[1:0];
      end
      3'b001: begin
        st_wdata = {2{WriteData[15:0]}};
        st_wstrb = 4'b0011 << {DR[1], 1'b0};
      end
      3'b010:  st_wstrb = 4'b1111;
      default: st_wstrb = 4'b0000;
    endcase
  end

  // Lane comes from the address latched at request time, not the live DR.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    lane_d          = lane_q;
    f3_d            = f3_q;
    wb_alu_res_d    = wb_alu_res_q;
    wb_read_data_d  = wb_read_data_q;
    wb_pc_plus_4_d  = wb_pc_plus_4_q;
    wb_dr_num_d     = wb_dr_num_q;
    wb_result_src_d = wb_result_src_q;
    wb_reg_write_d  = wb_reg_write_q;
    stall           = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && !trap) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = {DR[MEM_AW-1:2], 2'b00};
          mem_wdata_d = st_wdata;
          mem_wstrb_d = st_wstrb;
          lane_d      = DR[1:0];
          f3_d        = funct3;
          stall       = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
    endcase

    if (stall) begin
      wb_reg_write_d = 1'b0;
    end else begin
      wb_alu_res_d    = DR;
      wb_pc_plus_4_d  = PC_plus_4;
      wb_dr_num_d     = DR_num;
      wb_result_src_d = ResultSrc;
      wb_reg_write_d  = RegWrite & ~trap;
      if (state_q == BUSY && !mem_we_q) wb_read_data_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      lane_q          <= '0;
      f3_q            <= '0;
      wb_alu_res_q    <= '0;
      wb_read_data_q  <= '0;
      wb_pc_plus_4_q  <= '0;
      wb_dr_num_q     <= '0;
      wb_result_src_q <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      lane_q          <= lane_d;
      f3_q            <= f3_d;
      wb_alu_res_q    <= wb_alu_res_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_pc_plus_4_q  <= wb_pc_plus_4_d;
      wb_dr_num_q     <= wb_dr_num_d;
      wb_result_src_q <= wb_result_src_d;
      wb_reg_write_q  <= wb_reg_write_d;
    end
  end

  assign ALUResData   = DR;
  assign StallReq     = stall;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign WB_ALURes    = wb_alu_res_q;
  assign WB_ReadData  = wb_read_data_q;
  assign WB_PC_plus_4 = wb_pc_plus_4_q;
  assign WB_DR_num    = wb_dr_num_q;
  assign WB_ResultSrc = wb_result_src_q;
  assign WB_RegWrite  = wb_reg_write_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a write-back scoreboard queue and
// hand-written reset/idle corner sequences.
module tb_mem_access_stage;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DR, WriteData, PC_plus_4, mem_rdata;
  logic [4:0]  DR_num;
  logic [1:0]  ResultSrc;
  logic        RegWrite, MemWrite, MemRead, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] ALUResData, mem_addr, mem_wdata;
  logic        StallReq, mem_req, mem_we, MisalignErr;
  logic [3:0]  mem_wstrb;
  logic [31:0] WB_ALURes, WB_ReadData, WB_PC_plus_4;
  logic [4:0]  WB_DR_num;
  logic [1:0]  WB_ResultSrc;
  logic        WB_RegWrite;

  mem_access_stage #(.MEM_AW(32)) dut (
    .clk(clk), .reset(reset), .DR(DR), .DR_num(DR_num), .WriteData(WriteData),
    .PC_plus_4(PC_plus_4), .ResultSrc(ResultSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3),
    .ALUResData(ALUResData), .StallReq(StallReq), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .WB_ALURes(WB_ALURes),
    .WB_ReadData(WB_ReadData), .WB_PC_plus_4(WB_PC_plus_4), .WB_DR_num(WB_DR_num),
    .WB_ResultSrc(WB_ResultSrc), .WB_RegWrite(WB_RegWrite), .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd, wr, rw, misal;
    logic [2:0]  f3;
    logic [31:0] dr, wd, rdata;
    logic [4:0]  num;
    int unsigned dly;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wstrb;
  } vec_t;

  typedef struct {
    logic [31:0] alu, rd, pc;
    bit          chk_rd;
    logic [4:0]  num;
    logic [1:0]  rs;
    logic        rw, merr;
  } wb_exp_t;

  vec_t        vecs[13];
  wb_exp_t     sb[$];
  int unsigned n_tests = 0, n_fail = 0;
  logic [31:0] last_alu = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] dr, logic [31:0] wd,
                              logic [31:0] rdata, logic [4:0] num, bit rw, int unsigned dly,
                              bit misal, logic [31:0] e_addr, logic [31:0] e_wdata,
                              logic [3:0] e_wstrb, logic [31:0] e_rd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.dr = dr; v.wd = wd; v.rdata = rdata; v.num = num;
    v.rw = rw; v.dly = dly; v.misal = misal; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wstrb = e_wstrb; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic drive_nop();
    MemRead = 0; MemWrite = 0; RegWrite = 0; funct3 = 0; DR = 0; WriteData = 0;
    DR_num = 0; PC_plus_4 = 0; ResultSrc = 0; mem_rdata = 0;
  endtask

  task automatic run_op(input vec_t v, input int unsigned idx);
    wb_exp_t     e;
    bit          acc, trap;
    int unsigned stalls, busy;
    acc  = v.rd | v.wr;
    trap = acc & v.misal & TRAP_EN;
    MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; DR = v.dr; WriteData = v.wd;
    mem_rdata = v.rdata; DR_num = v.num; RegWrite = v.rw; mem_ready = 0;
    PC_plus_4 = 32'h1000 + 4 * idx; ResultSrc = 2'(idx);
    e.alu = v.dr; e.rd = v.e_rd; e.chk_rd = v.rd & ~v.wr & ~trap; e.pc = 32'h1000 + 4 * idx;
    e.num = v.num; e.rs = 2'(idx); e.rw = v.rw & ~trap; e.merr = trap;
    sb.push_back(e);
    #1;
    chk($sformatf("v%0d fwd", idx), ALUResData, v.dr);
    stalls = StallReq ? 1 : 0;
    if (acc && !trap) begin
      busy = 0;
      while (StallReq && busy <= 20) begin
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d req", idx), 32'(mem_req), 32'd1);
        chk($sformatf("v%0d addr", idx), mem_addr, v.e_addr);
        chk($sformatf("v%0d we", idx), 32'(mem_we), 32'(v.wr));
        if (v.wr) begin
          chk($sformatf("v%0d wdata", idx), mem_wdata, v.e_wdata);
          chk($sformatf("v%0d wstrb", idx), 32'(mem_wstrb), 32'(v.e_wstrb));
        end
        chk($sformatf("v%0d bubble", idx), 32'(WB_RegWrite), 32'd0);
        chk($sformatf("v%0d wb_hold", idx), WB_ALURes, last_alu);
        mem_ready = (busy == v.dly);
        busy++;
        #1;
        if (StallReq) stalls++;
      end
      chk($sformatf("v%0d busy_cycles", idx), busy, v.dly + 1);
    end else begin
      chk($sformatf("v%0d req_idle", idx), 32'(mem_req), 32'd0);
    end
    chk($sformatf("v%0d stalls", idx), stalls, (acc && !trap) ? v.dly + 1 : 0);
    @(posedge clk); @(negedge clk);
    mem_ready = 0;
    e = sb.pop_front();
    chk($sformatf("v%0d wb_alu", idx), WB_ALURes, e.alu);
    chk($sformatf("v%0d wb_pc", idx), WB_PC_plus_4, e.pc);
    chk($sformatf("v%0d wb_num", idx), 32'(WB_DR_num), 32'(e.num));
    chk($sformatf("v%0d wb_rs", idx), 32'(WB_ResultSrc), 32'(e.rs));
    chk($sformatf("v%0d wb_rw", idx), 32'(WB_RegWrite), 32'(e.rw));
    if (e.chk_rd) chk($sformatf("v%0d wb_rd", idx), WB_ReadData, e.rd);
    chk($sformatf("v%0d req_done", idx), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d merr", idx), 32'(MisalignErr), 32'(e.merr));
    last_alu = e.alu;
  endtask

  initial begin
    //          rd wr f3      dr            wd            rdata         num rw dly mis addr          wdata         strb     rd
    vecs[0]  = mk(0, 0, 3'b000, 32'h55,       32'h0,        32'h0,        7,  1, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h0);
    vecs[1]  = mk(0, 1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h0,        0,  0, 2, 0, 32'h100,     32'hDEADBEEF, 4'b1111, 32'h0);
    vecs[2]  = mk(1, 0, 3'b000, 32'h203,      32'h0,        32'h80FF1234, 5,  1, 0, 0, 32'h200,     32'h0,        4'b0000, 32'hFFFFFF80);
    vecs[3]  = mk(1, 0, 3'b101, 32'h202,      32'h0,        32'h80FF1234, 6,  1, 1, 0, 32'h200,     32'h0,        4'b0000, 32'h000080FF);
    vecs[4]  = mk(0, 1, 3'b001, 32'h202,      32'h0000ABCD, 32'h0,        0,  0, 0, 0, 32'h200,     32'hABCDABCD, 4'b1100, 32'h0);
    vecs[5]  = mk(0, 1, 3'b000, 32'h101,      32'h12345677, 32'h0,        0,  0, 1, 0, 32'h100,     32'h77777777, 4'b0010, 32'h0);
    vecs[6]  = mk(1, 0, 3'b001, 32'h200,      32'h0,        32'h12348001, 9,  1, 0, 0, 32'h200,     32'h0,        4'b0000, 32'hFFFF8001);
    vecs[7]  = mk(1, 0, 3'b100, 32'h201,      32'h0,        32'h0000A500, 10, 1, 3, 0, 32'h200,     32'h0,        4'b0000, 32'h000000A5);
    vecs[8]  = mk(1, 0, 3'b010, 32'h101,      32'h0,        32'h80FF1234, 11, 1, 0, 1, 32'h100,     32'h0,        4'b0000, 32'h80FF1234);
    vecs[9]  = mk(0, 0, 3'b000, 32'hCAFE,     32'h0,        32'h0,        31, 1, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h0);
    vecs[10] = mk(1, 0, 3'b001, 32'h203,      32'h0,        32'h80FF1234, 12, 1, 1, 1, 32'h200,     32'h0,        4'b0000, 32'hFFFF80FF);
    vecs[11] = mk(1, 0, 3'b011, 32'h10,       32'h0,        32'hFFFFFFFF, 13, 1, 0, 0, 32'h10,      32'h0,        4'b0000, 32'h0);
    vecs[12] = mk(1, 1, 3'b010, 32'h40,       32'h11223344, 32'h0,        14, 0, 0, 0, 32'h40,      32'h11223344, 4'b1111, 32'h0);

    reset = 1; mem_ready = 0;
    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst wb_alu", WB_ALURes, 32'h0);
    chk("rst wb_rw", 32'(WB_RegWrite), 32'd0);
    chk("rst merr", 32'(MisalignErr), 32'd0);
    reset = 0;

    for (int i = 0; i < 13; i++) run_op(vecs[i], i);

    // mem_ready while idle must not start or complete anything
    drive_nop();
    mem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("idle_ready stall", 32'(StallReq), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("idle_ready req", 32'(mem_req), 32'd0);
    end
    mem_ready = 0;

    // reset while BUSY abandons the access
    MemRead = 1; funct3 = 3'b010; DR = 32'h300; RegWrite = 1; DR_num = 3;
    PC_plus_4 = 32'h2000; mem_rdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    chk("rstbusy req", 32'(mem_req), 32'd1);
    reset = 1;
    drive_nop();
    @(posedge clk); @(negedge clk);
    reset = 0; mem_ready = 1;
    #1;
    chk("rstbusy stall", 32'(StallReq), 32'd0);
    chk("rstbusy req0", 32'(mem_req), 32'd0);
    chk("rstbusy addr", mem_addr, 32'h0);
    chk("rstbusy wb_alu", WB_ALURes, 32'h0);
    chk("rstbusy wb_pc", WB_PC_plus_4, 32'h0);
    chk("rstbusy wb_num", 32'(WB_DR_num), 32'd0);
    chk("rstbusy wb_rw", 32'(WB_RegWrite), 32'd0);
    @(posedge clk); @(negedge clk);
    mem_ready = 0;
    chk("rstbusy late_ready req", 32'(mem_req), 32'd0);
    chk("rstbusy late_ready rd", WB_ReadData, 32'h0);
    chk("rstbusy late_ready rw", 32'(WB_RegWrite), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
